mod_audio_dac_dsp_tx: RTL and testbench

//  Streams stereo 16-bit samples to the WM8731 DAC in DSP mode B (LRP=1, 16-bit, codec slave).

---
 rtl/mod_audio_dac_dsp_tx.sv | 172 +++++++++++++++++
 tb/tb_mod_audio_dac_dsp_tx.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_audio_dac_dsp_tx.sv
// -----------------------------------------------------------------------------
// mod_audio_dac_dsp_tx
// Streams stereo 16-bit sample pairs to a WM8731 DAC in DSP mode B (LRP=1,
// 16-bit words, codec as slave). This block is the BCLK/DACLRC master.
//
// Frame layout (one slot = one BCLK period, data launched on BCLK fall):
//   slot 0        lrc=1, dat=L[15]
//   slots 0..15   L[15..0]
//   slots 16..31  R[15..0]
//   slots 32..    dat=0, lrc=0
//
// State table
//   state | meaning
//   IDLE  | BCLK/LRC/DAT held low, waiting for i_enable
//   RUN   | streaming frames, a new frame loads at every frame boundary
//   DRAIN | i_enable dropped, current frame finishes then back to IDLE
//
// Ports
//   i_clk, i_nrst         clock, async active-low reset
//   i_enable              start/continue streaming
//   i_sample_left/right   sample pair, passed verbatim
//   i_sample_valid        pair valid; captured when o_sample_ready is high
//   o_sample_ready        shadow register empty
//   o_underrun            1-cycle pulse when a frame loads with shadow empty
//   o_dac_bclk/lrc/dat    codec serial interface
//   o_state               debug: 0 IDLE, 1 RUN, 2 DRAIN
// -----------------------------------------------------------------------------
module mod_audio_dac_dsp_tx #(
    parameter int CLK_DIV_HALF   = 4,
    parameter int BITS_PER_FRAME = 128
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_enable,
    input  logic [15:0] i_sample_left,
    input  logic [15:0] i_sample_right,
    input  logic        i_sample_valid,
    output logic        o_sample_ready,
    output logic        o_underrun,
    output logic        o_dac_bclk,
    output logic        o_dac_lrc,
    output logic        o_dac_dat,
    output logic [1:0]  o_state
);

    localparam int DIV_W  = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
    localparam int SLOT_W = $clog2(BITS_PER_FRAME);
    localparam logic [DIV_W-1:0]  DIV_TC    = DIV_W'(CLK_DIV_HALF - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BITS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              bclk_q, bclk_d;
    logic              lrc_q, lrc_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       shadow_q, shadow_d;
    logic              shadow_full_q, shadow_full_d;
    logic              underrun_q, underrun_d;
    // Keeps ready low while reset is held; set on the first clock after release.
    logic              ready_en_q;

    logic tick, fall, frame_end, frame_load, accept;

    assign o_sample_ready = ready_en_q & ~shadow_full_q;
    assign accept         = i_sample_valid & o_sample_ready;
    assign tick           = (div_cnt_q == DIV_TC);
    assign fall           = tick & bclk_q;
    assign frame_end      = fall & (slot_q == SLOT_LAST);

    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        slot_d        = slot_q;
        bclk_d        = bclk_q;
        lrc_d         = lrc_q;
        shift_d       = shift_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        underrun_d    = 1'b0;
        frame_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = '0;
                slot_d    = '0;
                bclk_d    = 1'b0;
                lrc_d     = 1'b0;
                shift_d   = '0;
                if (i_enable) begin
                    state_d    = ST_RUN;
                    frame_load = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
                if (tick) bclk_d = ~bclk_q;
                if (fall) begin
                    slot_d  = frame_end ? '0 : slot_q + SLOT_W'(1);
                    shift_d = {shift_q[30:0], 1'b0};
                    lrc_d   = 1'b0;
                end
                if (state_q == ST_RUN && !i_enable)  state_d = ST_DRAIN;
                if (state_q == ST_DRAIN && i_enable) state_d = ST_RUN;
                if (frame_end) begin
                    if (state_q == ST_RUN || i_enable) begin
                        frame_load = 1'b1;
                    end else begin
                        // Shift register is already empty after a full frame.
                        state_d   = ST_IDLE;
                        div_cnt_d = '0;
                        bclk_d    = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_load) begin
            shift_d       = shadow_full_q ? shadow_q : 32'd0;
            lrc_d         = 1'b1;
            underrun_d    = ~shadow_full_q;
            shadow_full_d = 1'b0;
        end

        // Accept only when empty, so a capture in a load cycle always targets
        // the next frame; the frame loading now has already seen it empty.
        if (accept) begin
            shadow_d      = {i_sample_left, i_sample_right};
            shadow_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q       <= ST_IDLE;
            div_cnt_q     <= '0;
            slot_q        <= '0;
            bclk_q        <= 1'b0;
            lrc_q         <= 1'b0;
            shift_q       <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            underrun_q    <= 1'b0;
            ready_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            slot_q        <= slot_d;
            bclk_q        <= bclk_d;
            lrc_q         <= lrc_d;
            shift_q       <= shift_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            underrun_q    <= underrun_d;
            ready_en_q    <= 1'b1;
        end
    end

    assign o_dac_bclk = bclk_q;
    assign o_dac_lrc  = lrc_q;
    assign o_dac_dat  = shift_q[31];
    assign o_underrun = underrun_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_mod_audio_dac_dsp_tx.sv
module tb_mod_audio_dac_dsp_tx;

    localparam int CLK_DIV_HALF = 4;
    localparam int BPF          = 128;
    localparam int FRAME_CYC    = 2 * CLK_DIV_HALF * BPF;
    localparam int LIMIT        = 5000;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        enable = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] left = '0;
    logic [15:0] right = '0;
    logic        ready, underrun, bclk, lrc, dat;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;
    int und_cnt  = 0;
    int zero_err = 0;

    logic [31:0] sb_q[$];
    int          mon_bits = 0;
    logic [31:0] mon_word = '0;
    bit          mon_active = 1'b0;

    mod_audio_dac_dsp_tx #(.CLK_DIV_HALF(CLK_DIV_HALF), .BITS_PER_FRAME(BPF)) dut (
        .i_clk          (clk),
        .i_nrst         (nrst),
        .i_enable       (enable),
        .i_sample_left  (left),
        .i_sample_right (right),
        .i_sample_valid (valid),
        .o_sample_ready (ready),
        .o_underrun     (underrun),
        .o_dac_bclk     (bclk),
        .o_dac_lrc      (lrc),
        .o_dac_dat      (dat),
        .o_state        (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (underrun === 1'b1) und_cnt++;

    // Frame monitor: codec-side view, sampling on BCLK rise.
    always @(posedge bclk or negedge nrst) begin
        if (!nrst) begin
            mon_active = 1'b0;
            mon_bits   = 0;
        end else begin
            if (lrc === 1'b1) begin
                if (mon_active) begin
                    n_checks++;
                    if (mon_bits !== BPF) begin
                        n_fail++;
                        $display("FAIL frame_len: got %0d bits, want %0d", mon_bits, BPF);
                    end
                end
                mon_active = 1'b1;
                mon_bits   = 1;
                mon_word   = {31'b0, dat};
            end else if (mon_active) begin
                mon_bits++;
                if (mon_bits <= 32) mon_word = {mon_word[30:0], dat};
                else if (dat !== 1'b0) zero_err++;
            end
            if (mon_active && mon_bits == 32) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_unexpected: got %08h, nothing expected", mon_word);
                end else begin
                    logic [31:0] exp;
                    exp = sb_q.pop_front();
                    if (mon_word !== exp) begin
                        n_fail++;
                        $display("FAIL frame_data: got %08h, want %08h", mon_word, exp);
                    end
                end
            end
        end
    end

    task automatic wait_lrc_rise(output bit ok);
        logic prev;
        prev = lrc;
        ok = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            @(posedge clk); #1;
            if (lrc === 1'b1 && prev !== 1'b1) begin ok = 1'b1; break; end
            prev = lrc;
        end
    endtask

    task automatic wait_bclk_falls(input int n, output bit ok);
        logic prev;
        int   seen;
        prev = bclk;
        seen = 0;
        ok = (n == 0);
        for (int i = 0; i < LIMIT && !ok; i++) begin
            @(posedge clk); #1;
            if (bclk === 1'b0 && prev === 1'b1) seen++;
            prev = bclk;
            if (seen == n) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            @(posedge clk); #1;
            if (state === 2'd0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic send_pair(input logic [15:0] l, input logic [15:0] r, output bit ok);
        logic acc;
        sb_q.push_back({l, r});
        left = l; right = r; valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            acc = ready;
            @(posedge clk); #1;
            if (acc === 1'b1) begin ok = 1'b1; break; end
        end
        valid = 1'b0;
    endtask

    task automatic check_bit(input string name, input bit ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s: got timeout/false, want true", name); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bclk, lrc, dat, underrun, ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b, want 00000", {bclk, lrc, dat, underrun, ready});
        end
        n_checks++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, want 0", state); end
        nrst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b, want 1", ready); end
        n_checks++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL release_state: got %0d, want 0", state); end
    endtask

    task automatic test_frame_format();
        bit  ok;
        time t0, t1, r1, r2;
        int  lrc_hi;
        logic prev_b;
        send_pair(16'hA5C3, 16'h0F0F, ok);
        check_bit("preload_accept", ok);
        enable = 1'b1;
        wait_lrc_rise(ok);
        check_bit("first_frame_start", ok);
        t0 = $time; lrc_hi = 1; r1 = 0; r2 = 0; prev_b = bclk;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (lrc === 1'b1 && i < 16) lrc_hi++;
            if (bclk === 1'b1 && prev_b !== 1'b1) begin
                if (r1 == 0) r1 = $time; else if (r2 == 0) r2 = $time;
            end
            prev_b = bclk;
        end
        n_checks++;
        if (lrc_hi !== 2 * CLK_DIV_HALF) begin
            n_fail++; $display("FAIL lrc_width: got %0d cycles, want %0d", lrc_hi, 2 * CLK_DIV_HALF);
        end
        n_checks++;
        if (r1 - t0 !== CLK_DIV_HALF * 10) begin
            n_fail++; $display("FAIL first_rise: got %0t, want %0d", r1 - t0, CLK_DIV_HALF * 10);
        end
        n_checks++;
        if (r2 - r1 !== 2 * CLK_DIV_HALF * 10) begin
            n_fail++; $display("FAIL bclk_period: got %0t, want %0d", r2 - r1, 2 * CLK_DIV_HALF * 10);
        end
        sb_q.push_back(32'h0);
        wait_lrc_rise(ok);
        check_bit("second_frame_start", ok);
        t1 = $time;
        n_checks++;
        if (t1 - t0 !== FRAME_CYC * 10) begin
            n_fail++; $display("FAIL frame_period: got %0t, want %0d", t1 - t0, FRAME_CYC * 10);
        end
        enable = 1'b0;
        wait_idle(ok);
        check_bit("frame_idle", ok);
    endtask

    task automatic test_underrun();
        bit ok;
        int u0;
        u0 = und_cnt;
        repeat (3) sb_q.push_back(32'h0);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_lrc_rise(ok);
            check_bit("underrun_frame_start", ok);
        end
        send_pair(16'h8000, 16'h7FFF, ok);
        check_bit("underrun_supply", ok);
        wait_lrc_rise(ok);
        check_bit("supplied_frame_start", ok);
        @(negedge clk); #1;
        n_checks++;
        if (und_cnt - u0 !== 3) begin
            n_fail++; $display("FAIL underrun_count: got %0d, want 3", und_cnt - u0);
        end
        enable = 1'b0;
        wait_idle(ok);
        check_bit("underrun_idle", ok);
    endtask

    task automatic test_load_collision();
        bit ok;
        int u0;
        u0 = und_cnt;
        // Entry cycle is a load with shadow empty; valid lands on it.
        sb_q.push_back(32'h0);
        sb_q.push_back({16'h1357, 16'h2468});
        left = 16'h1357; right = 16'h2468; valid = 1'b1; enable = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        n_checks++;
        if (lrc !== 1'b1 || ready !== 1'b0) begin
            n_fail++; $display("FAIL entry_collision: got lrc=%b ready=%b, want lrc=1 ready=0", lrc, ready);
        end
        wait_lrc_rise(ok);
        check_bit("collision_frame2", ok);
        // Same collision at an end-of-frame load.
        repeat (FRAME_CYC - 1) @(posedge clk);
        #1;
        sb_q.push_back(32'h0);
        sb_q.push_back({16'hFEDC, 16'h0123});
        left = 16'hFEDC; right = 16'h0123; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        n_checks++;
        if (lrc !== 1'b1) begin n_fail++; $display("FAIL boundary_collision: got lrc=%b, want 1", lrc); end
        wait_lrc_rise(ok);
        check_bit("collision_frame4", ok);
        @(negedge clk); #1;
        n_checks++;
        if (und_cnt - u0 !== 2) begin
            n_fail++; $display("FAIL collision_underruns: got %0d, want 2", und_cnt - u0);
        end
        enable = 1'b0;
        wait_idle(ok);
        check_bit("collision_idle", ok);
    endtask

    task automatic test_back_to_back();
        logic [31:0] pairs [4];
        logic        acc;
        bit          ok;
        int          u0;
        pairs[0] = 32'h1111_EEEE; pairs[1] = 32'h2222_DDDD;
        pairs[2] = 32'h3333_CCCC; pairs[3] = 32'h4444_BBBB;
        u0 = und_cnt;
        valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            {left, right} = pairs[k];
            sb_q.push_back(pairs[k]);
            ok = 1'b0;
            for (int i = 0; i < LIMIT; i++) begin
                acc = ready;
                @(posedge clk); #1;
                if (acc === 1'b1) begin ok = 1'b1; break; end
            end
            check_bit("b2b_accept", ok);
            n_checks++;
            if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_drop: got %b, want 0", ready); end
            if (k == 0) enable = 1'b1;
        end
        valid = 1'b0;
        wait_lrc_rise(ok);
        check_bit("b2b_last_frame", ok);
        enable = 1'b0;
        wait_idle(ok);
        check_bit("b2b_idle", ok);
        n_checks++;
        if (und_cnt - u0 !== 0) begin
            n_fail++; $display("FAIL b2b_underruns: got %0d, want 0", und_cnt - u0);
        end
    endtask

    task automatic test_drain();
        bit   ok;
        time  t0;
        int   bad;
        send_pair(16'hC001, 16'h0DD5, ok);
        enable = 1'b1;
        wait_lrc_rise(ok);
        check_bit("drain_start", ok);
        t0 = $time;
        wait_bclk_falls(10, ok);
        enable = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (state !== 2'd2) begin n_fail++; $display("FAIL drain_state: got %0d, want 2", state); end
        wait_idle(ok);
        check_bit("drain_idle", ok);
        n_checks++;
        if ($time - t0 !== FRAME_CYC * 10) begin
            n_fail++; $display("FAIL drain_len: got %0t, want %0d", $time - t0, FRAME_CYC * 10);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bclk !== 1'b0 || lrc !== 1'b0 || state !== 2'd0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles, want 0", bad); end

        send_pair(16'hBEEF, 16'h4321, ok);
        enable = 1'b1;
        wait_lrc_rise(ok);
        check_bit("reenable_start", ok);
        t0 = $time;
        send_pair(16'h6A6A, 16'h9595, ok);
        check_bit("reenable_supply", ok);
        wait_bclk_falls(10, ok);
        enable = 1'b0;
        wait_bclk_falls(50, ok);
        check_bit("reenable_slot60", ok);
        n_checks++;
        if (state !== 2'd2) begin n_fail++; $display("FAIL slot60_state: got %0d, want 2", state); end
        enable = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL rerun_state: got %0d, want 1", state); end
        wait_lrc_rise(ok);
        check_bit("reenable_next_frame", ok);
        n_checks++;
        if ($time - t0 !== FRAME_CYC * 10) begin
            n_fail++; $display("FAIL no_gap: got %0t, want %0d", $time - t0, FRAME_CYC * 10);
        end
        enable = 1'b0;
        wait_idle(ok);
        check_bit("reenable_idle", ok);
    endtask

    task automatic test_reset_midframe();
        bit ok;
        send_pair(16'h1234, 16'h0800, ok);
        enable = 1'b1;
        wait_lrc_rise(ok);
        check_bit("rst_frame_start", ok);
        wait_bclk_falls(20, ok);
        repeat (CLK_DIV_HALF + 1) @(posedge clk);
        #1;
        n_checks++;
        if (bclk !== 1'b1 || dat !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: got bclk=%b dat=%b, want 1 1", bclk, dat);
        end
        #2 nrst = 1'b0;
        #1;
        n_checks++;
        if ({bclk, lrc, dat, ready, underrun} !== 5'b0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: got outs=%b state=%0d, want 00000 0", {bclk, lrc, dat, ready, underrun}, state);
        end
        sb_q.delete();
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ready !== 1'b1 || state !== 2'd0) begin
            n_fail++; $display("FAIL post_reset: got ready=%b state=%0d, want 1 0", ready, state);
        end
    endtask

    initial begin
        test_reset();
        test_frame_format();
        test_underrun();
        test_load_collision();
        test_back_to_back();
        test_drain();
        test_reset_midframe();
        repeat (50) @(posedge clk);
        #1;
        n_checks++;
        if (sb_q.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: got %0d, want 0", sb_q.size()); end
        n_checks++;
        if (zero_err !== 0) begin n_fail++; $display("FAIL tail_zero: got %0d nonzero bits, want 0", zero_err); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
